// File: rtl/bpt_pkg.sv
// Shared definitions for the branch prediction table: counter encoding, FSM states, default size.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package bpt_pkg;

    // Default number of table entries (power of two, at least 4)
    localparam int BPT_ENTRIES = 64;

    // 2-bit saturating counter encoding
    localparam logic [1:0] CTR_SNT = 2'b00;  // strong not-taken
    localparam logic [1:0] CTR_WNT = 2'b01;  // weak not-taken
    localparam logic [1:0] CTR_WT  = 2'b10;  // weak taken
    localparam logic [1:0] CTR_ST  = 2'b11;  // strong taken

    // Table controller states: initialisation sweep, then normal operation
    typedef enum logic {
        SWEEP = 1'b0,
        RUN   = 1'b1
    } bpt_state_e;

endpackage

// File: rtl/bpt_counter_next.sv
// Saturating next-state for a 2-bit branch counter given the resolved outcome.
// Latency: purely combinational, zero cycles.
// Backpressure: none; always produces a result.
module bpt_counter_next
    import bpt_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       taken_i,
    output logic [1:0] ctr_o
);

    // Step towards strong-taken on taken, towards strong-not-taken otherwise, clamping at the ends
    always_comb begin
        ctr_o = ctr_i;
        if (taken_i) begin
            if (ctr_i != CTR_ST) begin
                ctr_o = ctr_i + 2'd1;
            end
        end else begin
            if (ctr_i != CTR_SNT) begin
                ctr_o = ctr_i - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_pred_table.sv
// Direct-mapped branch target/direction table with 2-bit counters and a post-reset clearing sweep.
// Latency: lookup is combinational (zero cycles); updates land at the next rising edge, no bypass.
// Backpressure: none; updates presented before ready_o is high are dropped.
module branch_pred_table
    import bpt_pkg::*;
#(
    parameter int ENTRIES = BPT_ENTRIES,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] lookup_pc_i,
    output logic        pred_hit_o,
    output logic        prediction_o,
    output logic [31:0] pred_target_o,
    input  logic        update_en_i,
    input  logic [31:0] update_pc_i,
    input  logic        update_outcome_i,
    input  logic [31:0] update_target_i,
    output logic        ready_o
);

    localparam int TAG_W = 30 - IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

    // Table storage; contents are defined by the sweep, so no reset is needed
    logic             valid_q [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [31:0]      tgt_q   [ENTRIES];
    logic [1:0]       ctr_q   [ENTRIES];

    bpt_state_e       state_q, state_d;
    logic [IDX_W-1:0] sweep_idx_q, sweep_idx_d;

    logic [IDX_W-1:0] l_idx, u_idx;
    logic [TAG_W-1:0] l_tag, u_tag;
    logic             u_hit;
    logic [1:0]       u_ctr_next;
    logic             unused_pc_bits;

    assign l_idx = lookup_pc_i[IDX_W+1:2];
    assign l_tag = lookup_pc_i[31:IDX_W+2];
    assign u_idx = update_pc_i[IDX_W+1:2];
    assign u_tag = update_pc_i[31:IDX_W+2];

    // Byte-offset bits never participate in indexing or tagging
    assign unused_pc_bits = ^{lookup_pc_i[1:0], update_pc_i[1:0]};

    // Lookup reads storage directly, so a same-cycle update is not visible until the edge
    assign pred_hit_o    = ready_o & valid_q[l_idx] & (tag_q[l_idx] == l_tag);
    assign prediction_o  = pred_hit_o & ctr_q[l_idx][1];
    assign pred_target_o = pred_hit_o ? tgt_q[l_idx] : 32'd0;

    assign u_hit = valid_q[u_idx] & (tag_q[u_idx] == u_tag);

    bpt_counter_next u_ctr_next_calc (
        .ctr_i   (ctr_q[u_idx]),
        .taken_i (update_outcome_i),
        .ctr_o   (u_ctr_next)
    );

    // State register: reset restarts the sweep from index 0
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= SWEEP;
            sweep_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            sweep_idx_q <= sweep_idx_d;
        end
    end

    // Next state: leave SWEEP on the cycle that clears the last entry; the index holds there
    always_comb begin
        state_d     = state_q;
        sweep_idx_d = sweep_idx_q;
        case (state_q)
            SWEEP: begin
                if (sweep_idx_q == LAST_IDX) begin
                    state_d = RUN;
                end else begin
                    sweep_idx_d = sweep_idx_q + 1'b1;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = SWEEP;
            end
        endcase
    end

    // Outputs of the FSM: table is usable only once the sweep is done
    always_comb begin
        ready_o = 1'b0;
        case (state_q)
            RUN:     ready_o = 1'b1;
            default: ready_o = 1'b0;
        endcase
    end

    // Table writes: one entry per cycle, either the sweep slot or the updated branch's slot
    always_ff @(posedge clk_i) begin
        if (state_q == SWEEP) begin
            valid_q[sweep_idx_q] <= 1'b0;
            ctr_q[sweep_idx_q]   <= CTR_WNT;
        end else if (update_en_i) begin
            if (u_hit) begin
                ctr_q[u_idx] <= u_ctr_next;
                if (update_outcome_i) begin
                    tgt_q[u_idx] <= update_target_i;
                end
            end else if (update_outcome_i) begin
                // Taken miss evicts whatever occupied this slot
                valid_q[u_idx] <= 1'b1;
                tag_q[u_idx]   <= u_tag;
                tgt_q[u_idx]   <= update_target_i;
                ctr_q[u_idx]   <= CTR_WT;
            end
        end
    end

endmodule

// File: tb/tb_branch_pred_table.sv
// Testbench for branch_pred_table: directed scenarios plus randomized traffic against a table model.
// Latency: checks combinational lookup each cycle, model updated at each rising edge.
// Backpressure: n/a.
module tb_branch_pred_table;

    localparam int N = 64;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [31:0] lookup_pc;
    logic        pred_hit;
    logic        prediction;
    logic [31:0] pred_target;
    logic        update_en;
    logic [31:0] update_pc;
    logic        update_outcome;
    logic [31:0] update_target;
    logic        ready;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain arrays indexed by (pc/4) mod 64, tag = pc/256, counter 0..3
    bit          m_valid [N];
    int unsigned m_tag   [N];
    logic [31:0] m_tgt   [N];
    int          m_ctr   [N];
    int          m_cnt;      // rising edges seen since reset release

    // Outputs sampled during the most recent drive call
    logic        s_ready, s_hit, s_pred;
    logic [31:0] s_tgt;

    always #5 clk = ~clk;

    branch_pred_table dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .lookup_pc_i      (lookup_pc),
        .pred_hit_o       (pred_hit),
        .prediction_o     (prediction),
        .pred_target_o    (pred_target),
        .update_en_i      (update_en),
        .update_pc_i      (update_pc),
        .update_outcome_i (update_outcome),
        .update_target_i  (update_target),
        .ready_o          (ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs, check lookup against the model, then advance the model at the edge
    task automatic drive(input logic [31:0] lpc, input logic uen, input logic [31:0] upc,
                         input logic uout, input logic [31:0] utgt);
        int          li, ui;
        bit          mready, ehit;
        int unsigned ltag, utag;
        @(negedge clk);
        lookup_pc      = lpc;
        update_en      = uen;
        update_pc      = upc;
        update_outcome = uout;
        update_target  = utgt;
        #1;
        li     = int'((lpc >> 2) % N);
        ltag   = lpc >> 8;
        mready = (m_cnt >= N);
        ehit   = mready && m_valid[li] && (m_tag[li] == ltag);
        s_ready = ready;
        s_hit   = pred_hit;
        s_pred  = prediction;
        s_tgt   = pred_target;
        chk("ready",  {31'd0, s_ready}, {31'd0, mready});
        chk("hit",    {31'd0, s_hit},   {31'd0, ehit});
        chk("pred",   {31'd0, s_pred},  {31'd0, (ehit && m_ctr[li] >= 2)});
        chk("target", s_tgt, ehit ? m_tgt[li] : 32'd0);
        @(posedge clk);
        if (m_cnt < N) begin
            m_cnt++;
            if (m_cnt == N) begin
                for (int i = 0; i < N; i++) begin
                    m_valid[i] = 1'b0;
                    m_ctr[i]   = 1;
                end
            end
        end else if (uen) begin
            ui   = int'((upc >> 2) % N);
            utag = upc >> 8;
            if (m_valid[ui] && m_tag[ui] == utag) begin
                if (uout) begin
                    m_ctr[ui] = (m_ctr[ui] == 3) ? 3 : m_ctr[ui] + 1;
                    m_tgt[ui] = utgt;
                end else begin
                    m_ctr[ui] = (m_ctr[ui] == 0) ? 0 : m_ctr[ui] - 1;
                end
            end else if (uout) begin
                m_valid[ui] = 1'b1;
                m_tag[ui]   = utag;
                m_tgt[ui]   = utgt;
                m_ctr[ui]   = 2;
            end
        end
    endtask

    function automatic logic [31:0] rpc();
        int unsigned tags [4];
        tags = '{32'h0, 32'h1, 32'h12345, 32'hFFFFFF};
        return 32'((tags[$urandom_range(0, 3)] << 8) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
    endfunction

    task automatic drive_rand();
        drive(rpc(), 1'($urandom_range(0, 1)), rpc(), 1'($urandom_range(0, 1)), $urandom);
    endtask

    // Count cycles with ready low after a release; bounded so a stuck design still terminates
    task automatic measure_sweep(input string tag);
        int n    = 0;
        bit done = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            drive_rand();
            if (s_ready) done = 1;
            else n++;
        end
        chk(tag, 32'(n), 32'(N));
    endtask

    // Assert reset between edges, check outputs drop at once, then release just after an edge
    task automatic pulse_reset(input string tag);
        #2;
        rst_ni = 1'b0;
        #1;
        chk({tag, "_ready"},  {31'd0, ready},       32'd0);
        chk({tag, "_hit"},    {31'd0, pred_hit},    32'd0);
        chk({tag, "_pred"},   {31'd0, prediction},  32'd0);
        chk({tag, "_target"}, pred_target,          32'd0);
        repeat (3) @(posedge clk);
        #2;
        rst_ni = 1'b1;
        m_cnt  = 0;
    endtask

    initial begin
        rst_ni         = 1'b0;
        lookup_pc      = 32'h0;
        update_en      = 1'b0;
        update_pc      = 32'h0;
        update_outcome = 1'b0;
        update_target  = 32'h0;
        m_cnt          = 0;
        #1;
        chk("rst_ready",  {31'd0, ready},    32'd0);
        chk("rst_hit",    {31'd0, pred_hit}, 32'd0);
        chk("rst_target", pred_target,       32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_ni = 1'b1;
        m_cnt  = 0;
        measure_sweep("sweep_len_initial");

        // Allocate and hit
        drive(32'h100, 1'b1, 32'h100, 1'b1, 32'h200);
        drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("alloc_hit",    {31'd0, s_hit},  32'd1);
        chk("alloc_pred",   {31'd0, s_pred}, 32'd1);
        chk("alloc_target", s_tgt,           32'h200);

        // Saturate down: 10 -> 01 -> 00 -> 00
        repeat (3) drive(32'h100, 1'b1, 32'h100, 1'b0, 32'h0);
        drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("sat_down_hit",  {31'd0, s_hit},  32'd1);
        chk("sat_down_pred", {31'd0, s_pred}, 32'd0);
        // Saturate up: 00 -> 01 -> 10 -> 11, fourth stays 11
        repeat (4) drive(32'h100, 1'b1, 32'h100, 1'b1, 32'h200);
        drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("sat_up_pred", {31'd0, s_pred}, 32'd1);
        // One not-taken from 11 must still predict taken; from 10 it would not
        drive(32'h100, 1'b1, 32'h100, 1'b0, 32'h0);
        drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("sat_up_held", {31'd0, s_pred}, 32'd1);

        // Alias eviction on index 0
        drive(32'h100, 1'b1, 32'h200, 1'b1, 32'h300);
        drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("alias_old_miss", {31'd0, s_hit}, 32'd0);
        drive(32'h200, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("alias_new_hit",    {31'd0, s_hit}, 32'd1);
        chk("alias_new_target", s_tgt,          32'h300);

        // Not-taken miss leaves the table alone
        drive(32'h400, 1'b1, 32'h400, 1'b0, 32'h999);
        drive(32'h400, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("nt_miss_hit", {31'd0, s_hit}, 32'd0);
        drive(32'h200, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("nt_miss_keep", s_tgt, 32'h300);

        // Same-cycle lookup and update: old value now, new value next cycle
        drive(32'h200, 1'b1, 32'h200, 1'b1, 32'h500);
        chk("same_cycle_old", s_tgt, 32'h300);
        drive(32'h200, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("same_cycle_new", s_tgt, 32'h500);

        // Reset in RUN, then a full sweep again
        pulse_reset("rst_run");
        measure_sweep("sweep_len_after_run_reset");

        // Random traffic, a reset part-way through a sweep, then more random traffic
        repeat (600) drive_rand();
        pulse_reset("rst_run2");
        repeat (20) drive_rand();
        pulse_reset("rst_sweep");
        measure_sweep("sweep_len_after_sweep_reset");
        repeat (1000) drive_rand();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
